// File: rtl/param_dual_port_stack_if.sv
// One request/response port of the dual-port stack.
// master drives requests and consumes responses; slave is the stack side.
interface param_dual_port_stack_if #(
  parameter int DATA_W = 8
);
  logic              inp_valid;
  logic              inp_ready;
  logic [DATA_W-1:0] inp_data;
  logic [1:0]        inp_cmd;
  logic              outp_valid;
  logic              outp_ready;
  logic [DATA_W-1:0] outp_data;
  logic [1:0]        outp_cmd;
  logic              outp_err;

  modport master (
    output inp_valid, inp_data, inp_cmd, outp_ready,
    input  inp_ready, outp_valid, outp_data, outp_cmd, outp_err
  );

  modport slave (
    input  inp_valid, inp_data, inp_cmd, outp_ready,
    output inp_ready, outp_valid, outp_data, outp_cmd, outp_err
  );
endinterface

// File: rtl/param_dual_port_stack.sv
// Shared LIFO stack with two round-robin-arbitrated request/response ports.
// Latency: response registered 1 cycle after acceptance; count/full/empty update on the same edge.
// Backpressure: a port takes a request only when its response slot is free; over/underflow is answered with err.
module param_dual_port_stack #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 256,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  param_dual_port_stack_if.slave port0,
  param_dual_port_stack_if.slave port1,
  output logic [CNT_W-1:0]     count,
  output logic                 full,
  output logic                 empty
);

  localparam int               AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [1:0]       CMD_PUSH  = 2'b00;
  localparam logic [1:0]       CMD_POP   = 2'b01;
  localparam logic [1:0]       CMD_PEEK  = 2'b10;
  localparam logic [1:0]       CMD_CLEAR = 2'b11;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [CNT_W-1:0]  cnt_m1;
  logic              prio_q;

  logic [1:0]        req_vld;
  logic [1:0]        rsp_rdy;
  logic [1:0]        slot_free;
  logic [1:0]        rdy;
  logic [1:0]        grant;

  logic [1:0]        sel_cmd;
  logic [DATA_W-1:0] sel_data;
  logic [DATA_W-1:0] top_data;
  logic              wr_en;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  logic              rsp_vld_q [2];
  logic [DATA_W-1:0] rsp_dat_q [2];
  logic [1:0]        rsp_cmd_q [2];
  logic              rsp_err_q [2];

  assign req_vld   = {port1.inp_valid, port0.inp_valid};
  assign rsp_rdy   = {port1.outp_ready, port0.outp_ready};
  assign slot_free = {!rsp_vld_q[1] || rsp_rdy[1], !rsp_vld_q[0] || rsp_rdy[0]};

  // A port yields only when the other port could actually be granted and holds priority.
  assign rdy[0] = !rst && slot_free[0] && !(req_vld[1] && slot_free[1] &&  prio_q);
  assign rdy[1] = !rst && slot_free[1] && !(req_vld[0] && slot_free[0] && !prio_q);
  assign grant  = req_vld & rdy;

  assign port0.inp_ready = rdy[0];
  assign port1.inp_ready = rdy[1];

  assign sel_cmd  = grant[1] ? port1.inp_cmd  : port0.inp_cmd;
  assign sel_data = grant[1] ? port1.inp_data : port0.inp_data;
  assign cnt_m1   = cnt_q - CNT_W'(1);
  assign top_data = mem[cnt_m1[AW-1:0]];

  always_comb begin
    cnt_nxt  = cnt_q;
    wr_en    = 1'b0;
    rsp_data = '0;
    rsp_err  = 1'b0;
    if (|grant) begin
      case (sel_cmd)
        CMD_PUSH: begin
          rsp_data = sel_data;
          if (cnt_q == DEPTH_C) begin
            rsp_err = 1'b1;
          end else begin
            wr_en   = 1'b1;
            cnt_nxt = cnt_q + CNT_W'(1);
          end
        end
        CMD_POP: begin
          if (cnt_q == '0) begin
            rsp_err = 1'b1;
          end else begin
            rsp_data = top_data;
            cnt_nxt  = cnt_m1;
          end
        end
        CMD_PEEK: begin
          if (cnt_q == '0) rsp_err = 1'b1;
          else             rsp_data = top_data;
        end
        CMD_CLEAR: cnt_nxt = '0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[cnt_q[AW-1:0]] <= sel_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      prio_q <= 1'b0;
      for (int p = 0; p < 2; p++) begin
        rsp_vld_q[p] <= 1'b0;
        rsp_dat_q[p] <= '0;
        rsp_cmd_q[p] <= 2'b00;
        rsp_err_q[p] <= 1'b0;
      end
    end else begin
      cnt_q <= cnt_nxt;
      full  <= (cnt_nxt == DEPTH_C);
      empty <= (cnt_nxt == '0);
      if (grant[0])      prio_q <= 1'b1;
      else if (grant[1]) prio_q <= 1'b0;
      for (int p = 0; p < 2; p++) begin
        if (grant[p]) begin
          rsp_vld_q[p] <= 1'b1;
          rsp_dat_q[p] <= rsp_data;
          rsp_cmd_q[p] <= sel_cmd;
          rsp_err_q[p] <= rsp_err;
        end else if (rsp_rdy[p]) begin
          rsp_vld_q[p] <= 1'b0;
        end
      end
    end
  end

  assign count = cnt_q;

  assign port0.outp_valid = rsp_vld_q[0];
  assign port0.outp_data  = rsp_dat_q[0];
  assign port0.outp_cmd   = rsp_cmd_q[0];
  assign port0.outp_err   = rsp_err_q[0];
  assign port1.outp_valid = rsp_vld_q[1];
  assign port1.outp_data  = rsp_dat_q[1];
  assign port1.outp_cmd   = rsp_cmd_q[1];
  assign port1.outp_err   = rsp_err_q[1];

endmodule

// File: doc/param_dual_port_stack.md
PARAM_DUAL_PORT_STACK -- requirements
Module: param_dual_port_stack

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning data width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 256, meaning stack capacity in entries (>=2, any value, not necessarily a power of two).
REQ-003 SHALL have derived localparam CNT_W = clog2(DEPTH+1), meaning occupancy count width.
REQ-004 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-006 SHALL have, for each port p in {0,1}: inp_valid  input  1  request valid.
REQ-007 SHALL have inp_ready  output  1  request accepted when valid and ready are both high.
REQ-008 SHALL have inp_data  input  DATA_W  push operand.
REQ-009 SHALL have inp_cmd  input  2  00 PUSH, 01 POP, 10 PEEK, 11 CLEAR.
REQ-010 SHALL have outp_valid  output  1  response valid.
REQ-011 SHALL have outp_ready  input  1  response consumed when valid and ready are both high.
REQ-012 SHALL have outp_data  output  DATA_W  response data.
REQ-013 SHALL have outp_cmd  output  2  echo of the accepted request cmd.
REQ-014 SHALL have outp_err  output  1  1 = operation rejected (overflow/underflow).
REQ-015 SHALL have count  output  CNT_W  registered occupancy.
REQ-016 SHALL have full  output  1  registered (count == DEPTH).
REQ-017 SHALL have empty  output  1  registered (count == 0).

Function
REQ-018 SHALL hold one response slot per port; slot p is free when !outp_valid || outp_ready.
REQ-019 SHALL accept at most one request per cycle across both ports.
REQ-020 SHALL drive inp_ready = slot p free && not (other port valid, other slot free, other port has priority); inp_ready SHALL NOT depend on inp_valid or inp_cmd.
REQ-021 SHALL arbitrate round-robin with a 1-bit priority pointer: reset value port 0; after a grant to port k the pointer SHALL point to the other port; with no grant the pointer SHALL hold.
REQ-022 SHALL, for an accepted request, load outp_valid=1, outp_cmd, outp_data, outp_err on the same edge (response visible 1 cycle after acceptance).
REQ-023 PUSH, count<DEPTH: mem[count]<=inp_data, count+1, outp_data=inp_data, err=0; count==DEPTH: no state change, outp_data=inp_data, err=1.
REQ-024 POP, count>0: outp_data=mem[count-1], count-1, err=0; count==0: no state change, outp_data=0, err=1.
REQ-025 PEEK, count>0: outp_data=mem[count-1], count unchanged, err=0; count==0: outp_data=0, err=1.
REQ-026 CLEAR: count<=0, outp_data=0, err=0; memory contents need not be cleared.
REQ-027 SHALL keep the response stable until outp_valid&&outp_ready; on that edge without a new acceptance on port p, outp_valid SHALL fall to 0.
REQ-028 SHALL allow back-to-back: a response consumed and a new request accepted on the same port in the same cycle yields outp_valid held 1 with the new response.
REQ-029 SHALL compute full/empty/count from next-state count so they are consistent with the op on the same edge.
REQ-030 SHALL never deadlock on full or empty: over/underflow requests are accepted and answered with err=1.
REQ-031 SHALL make the port-1 view consistent: a push by one port followed by pop/peek by the other returns the pushed value.

Reset
REQ-032 On rst=1 at a rising edge: count=0, full=0, empty=1, out0/1_valid=0, out0/1_data=0, out0/1_cmd=00, out0/1_err=0, priority pointer=port 0.
REQ-033 Reset mid-operation SHALL discard pending responses and stack contents; no request SHALL be accepted in a reset cycle (in0/1_ready=0 while rst=1).

Verification
REQ-034 Reset, then port 0 PUSH 0xA5, out0_ready=1 -> next cycle out0_valid=1, cmd=00, data=0xA5, err=0; count=1, empty=0.
REQ-035 Port 0 PUSH 0x11, port 1 POP after it completes -> out1 data=0x11, cmd=01, err=0; count=0, empty=1.
REQ-036 Both ports valid every cycle, both out_ready=1 -> grants alternate 0,1,0,1 starting with port 0 after reset.
REQ-037 DEPTH=4: five PUSHes -> fifth returns err=1, count stays 4, full=1; then POP returns 4th pushed value; POP on empty -> err=1, data=0.
REQ-038 out0_ready=0 with out0_valid=1 -> in0_ready=0, port 1 still served; releasing out0_ready restores port 0 acceptance same cycle.
REQ-039 PEEK on 2 entries returns top, count unchanged; CLEAR -> count=0, empty=1; rst asserted with pending response -> out0/1_valid=0 next cycle.
